// File: rtl/gpu_pixel_writer.sv
// gpu_pixel_writer
//   Buffers accepted pixels as {framebuffer word address, colour} in a small
//   FIFO and issues them to the framebuffer one write at a time, holding each
//   request until the framebuffer acknowledges it.
//
// Optional feature macro: GPU_PIXEL_CLIP_EN
//   defined   -> pixels with X >= `WIDTH or Y >= `HEIGHT are accepted but
//                dropped, and counted in clip_cnt (saturating at 255)
//   undefined -> every pixel is written (address wraps), clip_cnt tied to 0
//
// Ports
//   clk        rising-edge clock
//   n_rst      asynchronous active-low reset
//   pix_valid  upstream pixel present
//   X, Y       pixel column / row
//   r_i/g_i/b_i pixel colour
//   pix_ready  FIFO not full; pixel taken when pix_valid && pix_ready
//   mem_wr     framebuffer write request
//   mem_addr   framebuffer word address (Y*`WIDTH + X, truncated)
//   mem_data   {r, g, b}, r in the MSBs
//   mem_ack    framebuffer accepted the current write
//   busy       FIFO non-empty or a write outstanding
//   clip_cnt   number of discarded pixels

`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_pixel_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 19
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       pix_valid,
  input  logic [`WIDTH_BITS-1:0]     X,
  input  logic [`HEIGHT_BITS-1:0]    Y,
  input  logic [`CHANNEL_BITS-1:0]   r_i,
  input  logic [`CHANNEL_BITS-1:0]   g_i,
  input  logic [`CHANNEL_BITS-1:0]   b_i,
  output logic                       pix_ready,
  output logic                       mem_wr,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [3*`CHANNEL_BITS-1:0] mem_data,
  input  logic                       mem_ack,
  output logic                       busy,
  output logic [7:0]                 clip_cnt
);

  localparam int DW = 3 * `CHANNEL_BITS;
  localparam int EW = ADDR_W + DW;
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [PW:0]       count_q, count_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;

  logic              full, empty, clip, accept, push, pop;
  logic [ADDR_W-1:0] pix_addr;
  logic [EW-1:0]     head;

  assign full      = (count_q == (PW+1)'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign pix_ready = !full;
  assign accept    = pix_valid && !full;

  // Arithmetic done directly at ADDR_W bits, so truncation is modular.
  assign pix_addr = ADDR_W'(Y) * ADDR_W'(`WIDTH) + ADDR_W'(X);

`ifdef GPU_PIXEL_CLIP_EN
  assign clip = (32'(X) >= 32'(`WIDTH)) || (32'(Y) >= 32'(`HEIGHT));
`else
  assign clip = 1'b0;
`endif

  assign push = accept && !clip;
  assign head = fifo_q[rptr_q];

  // FIFO storage needs no reset: only entries covered by count_q are read.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= {pix_addr, r_i, g_i, b_i};
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Write FSM: the head entry is loaded into the output registers on the
  // same edge it is popped, so an ack with data waiting chains back-to-back.
  always_comb begin
    state_d  = state_q;
    mem_wr_d = mem_wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_d  = WRITE;
          mem_wr_d = 1'b1;
          addr_d   = head[EW-1:DW];
          data_d   = head[DW-1:0];
        end
      end
      WRITE: begin
        if (mem_ack) begin
          if (!empty) begin
            pop    = 1'b1;
            addr_d = head[EW-1:DW];
            data_d = head[DW-1:0];
          end else begin
            state_d  = IDLE;
            mem_wr_d = 1'b0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      mem_wr_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      mem_wr_q <= mem_wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign mem_wr   = mem_wr_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign busy     = !empty || (state_q == WRITE);

`ifdef GPU_PIXEL_CLIP_EN
  logic [7:0] clip_q, clip_d;

  always_comb begin
    clip_d = clip_q;
    if (accept && clip && (clip_q != 8'hFF)) clip_d = clip_q + 8'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) clip_q <= '0;
    else        clip_q <= clip_d;
  end

  assign clip_cnt = clip_q;
`else
  assign clip_cnt = '0;
`endif

endmodule
